// File: rtl/counter_snapshot_fifo.sv
// rtl/counter_snapshot_fifo.sv - timestamp capture FIFO with drop counting and count monotonicity check
module counter_snapshot_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int DROPW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     event_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   out_level,
    output logic [DROPW-1:0]         drop_count,
    output logic                     overflow,
    output logic                     mono_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LEVEL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      level;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic             past_valid;
    logic [WIDTH-1:0] past_count;
    logic             drop_count_max;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a capture then.
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (level == FULL_LEVEL);
    assign push      = event_in && (!full || pop);
    assign drop      = event_in && full && !pop;
    assign out_data  = mem[rd_ptr];
    assign out_level = level;
    assign drop_count_max = &drop_count;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= count_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                level <= level + (PW + 1)'(1);
            end else if (pop && !push) begin
                level <= level - (PW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (!drop_count_max) begin
                drop_count <= drop_count + DROPW'(1);
            end
        end
    end

    // The first edge after reset only seeds past_count; checking starts one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            past_valid <= 1'b0;
            past_count <= '0;
            mono_err   <= 1'b0;
        end else begin
            past_valid <= 1'b1;
            past_count <= count_in;
            if (past_valid && (count_in != past_count + WIDTH'(1))) begin
                mono_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_snapshot_fifo.sv
// tb/tb_counter_snapshot_fifo.sv - queue-model bench for counter_snapshot_fifo
module tb_counter_snapshot_fifo;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int DROPW = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] count_in = '0;
    logic             event_in = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_level;
    logic [DROPW-1:0] drop_count;
    logic             overflow;
    logic             mono_err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    logic [63:0] cnt = '0;

    logic [63:0] mq[$];
    int          m_drop = 0;
    bit          m_ovf = 1'b0;
    bit          m_mono = 1'b0;
    bit          m_pv = 1'b0;
    logic [63:0] m_pc = '0;

    counter_snapshot_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROPW(DROPW)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .event_in(event_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_level(out_level), .drop_count(drop_count), .overflow(overflow),
        .mono_err(mono_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: pop the head first, then the capture takes the freed slot.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_drop = 0;
            m_ovf  = 1'b0;
            m_mono = 1'b0;
            m_pv   = 1'b0;
            m_pc   = '0;
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (event_in) begin
                if (mq.size() < DEPTH) mq.push_back(count_in);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if (m_pv && count_in != m_pc + 64'd1) m_mono = 1'b1;
            m_pc = count_in;
            m_pv = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
            chk("model_level", {61'd0, out_level}, 64'(mq.size()));
            if (mq.size() != 0) chk("model_data", out_data, mq[0]);
            chk("model_drop", {56'd0, drop_count}, 64'(m_drop));
            chk("model_ovf", {63'd0, overflow}, {63'd0, m_ovf});
            chk("model_mono", {63'd0, mono_err}, {63'd0, m_mono});
        end
    end

    task automatic tick(input logic ev, input logic rdy);
        count_in  = cnt;
        event_in  = ev;
        out_ready = rdy;
        @(posedge clk);
        #1;
        cnt = cnt + 64'd1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // Single capture with stall, then pop
        cnt = 64'h10;
        do_reset(2);
        chk_en = 1'b1;
        chk("reset_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_level", {61'd0, out_level}, 64'd0);
        tick(1'b1, 1'b0);
        chk("single_valid", {63'd0, out_valid}, 64'd1);
        chk("single_data", out_data, 64'h12);
        chk("single_level", {61'd0, out_level}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            chk("stall_data", out_data, 64'h12);
        end
        tick(1'b0, 1'b1);
        chk("pop_level", {61'd0, out_level}, 64'd0);

        // Fill and overflow
        do_reset(2);
        cnt = 64'h100;
        repeat (6) tick(1'b1, 1'b0);
        chk("fill_level", {61'd0, out_level}, 64'd4);
        chk("fill_drop", {56'd0, drop_count}, 64'd2);
        chk("fill_ovf", {63'd0, overflow}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", out_data, 64'h100 + 64'(i));
            tick(1'b0, 1'b1);
        end
        chk("drain_empty", {63'd0, out_valid}, 64'd0);

        // Simultaneous push and pop at full
        do_reset(2);
        cnt = 64'h200;
        repeat (4) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("pp_level", {61'd0, out_level}, 64'd4);
        chk("pp_drop", {56'd0, drop_count}, 64'd0);
        chk("pp_ovf", {63'd0, overflow}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("pp_order", out_data, 64'h201 + 64'(i));
            tick(1'b0, 1'b1);
        end

        // Wrap-around of the count is legal
        do_reset(2);
        cnt = 64'hFFFF_FFFF_FFFF_FFFD;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("wrap_mono", {63'd0, mono_err}, 64'd0);
        chk("wrap_data", out_data, 64'd0);
        tick(1'b0, 1'b1);

        // Held count is a violation and sticks
        do_reset(2);
        cnt = 64'd4;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("mono_before", {63'd0, mono_err}, 64'd0);
        cnt = 64'd6;
        tick(1'b0, 1'b0);
        chk("mono_set", {63'd0, mono_err}, 64'd1);
        repeat (20) tick(1'b0, 1'b0);
        chk("mono_sticky", {63'd0, mono_err}, 64'd1);

        // Reset mid-operation with an event in the reset cycle
        do_reset(2);
        cnt = 64'h300;
        repeat (5) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        chk("mid_level", {61'd0, out_level}, 64'd3);
        chk("mid_ovf", {63'd0, overflow}, 64'd1);
        rst = 1'b1;
        tick(1'b1, 1'b0);
        rst = 1'b0;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_level", {61'd0, out_level}, 64'd0);
        chk("rst_drop", {56'd0, drop_count}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        cnt = 64'h1000;
        tick(1'b0, 1'b0);
        chk("rst_unchecked", {63'd0, mono_err}, 64'd0);
        cnt = 64'h2000;
        tick(1'b0, 1'b0);
        chk("rst_checked", {63'd0, mono_err}, 64'd1);
        tick(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_snapshot_fifo.md
Name: counter_snapshot_fifo

Overview:
- Downstream consumer of the free-running counter's WIDTH-bit count output.
- On each event pulse it captures the current count into a small FIFO and presents the timestamps on a valid/ready stream.
- It also checks every cycle that the count advances by exactly one, with wrap-around allowed, and flags any violation.
- It counts timestamps dropped on overflow.

Parameters:
- WIDTH, 64: width of count_in and out_data.
- DEPTH, 4: number of FIFO entries. Must be a power of two, 2..16.
- DROPW, 8: width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  live counter value, sampled every cycle.
- event_in  input  1  capture request; the count_in value on the same edge is captured.
- out_valid  output  1  FIFO head holds a timestamp.
- out_ready  input  1  consumer accepts the head this cycle.
- out_data  output  WIDTH  timestamp at the FIFO head.
- out_level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- drop_count  output  DROPW  number of dropped captures; saturates at all-ones.
- overflow  output  1  sticky flag; set on the first drop.
- mono_err  output  1  sticky flag; set when the count does not advance by exactly one.

Behaviour:
- Reset values (rst high at a clk edge):
  - out_valid=0, out_level=0, drop_count=0, overflow=0, mono_err=0.
  - Read and write pointers = 0.
  - past_valid=0, past_count=0.
  - out_data is don't-care while out_valid=0.
  - FIFO storage is not reset.
- Reset mid-operation: rst discards all stored entries on the same edge. Any event or pop in that cycle is ignored.
- Push:
  - A push happens when event_in=1 and (level<DEPTH, or a pop occurs this cycle).
  - On push, count_in is written at the write pointer and the write pointer increments modulo DEPTH.
- Pop: a pop happens when out_valid=1 and out_ready=1. On pop, the read pointer increments modulo DEPTH.
- Latency:
  - A value captured at edge N is visible on out_data, with out_valid=1, after edge N (cycle N+1) when the FIFO was empty.
  - There is no combinational path from event_in to out_valid.
- Level update:
  - level += push − pop.
  - Simultaneous push and pop at full keeps level=DEPTH and accepts the new entry.
  - Simultaneous push and pop at level 1 keeps out_valid=1 and presents the new entry next cycle.
- Ordering: strict FIFO. out_data = mem[rd_ptr], a registered read path or a mux from registered storage.
- out_valid=(level!=0). It must be stable while out_ready=0; the head does not change without a pop.
- Drop:
  - A drop happens when event_in=1, level==DEPTH and there is no pop.
  - The entry is discarded. overflow is set to 1 and stays set until rst.
  - drop_count increments unless it is already all-ones.
- Monotonic check:
  - past_count registers count_in every cycle. past_valid becomes 1 on the first edge after reset.
  - When past_valid=1 and count_in != past_count+1 (modulo 2^WIDTH), mono_err is set at the next edge and stays set until rst.
  - The wrap from all-ones to 0 is legal.
  - A held value (count_in == past_count) is an error.
  - The cycle immediately after reset is never checked.
- Arithmetic: all pointer and level arithmetic is unsigned. The pointers use $clog2(DEPTH) bits and wrap naturally.
- No X propagation: outputs are defined every cycle after reset.

Test Plan:
- Single capture:
  - Stimulus: rst 2 cycles; count_in=0x10 incrementing each cycle; event_in=1 at count 0x12 with out_ready=0.
  - Response: out_valid=1 next cycle with out_data=0x12 and out_level=1. out_data holds 0x12 for 3 stalled cycles; a pop with out_ready=1 drops out_level to 0.
- Fill and overflow:
  - Stimulus: DEPTH=4, out_ready=0, event_in=1 for 6 consecutive cycles starting at count 0x100.
  - Response: out_level=4; drop_count=2; overflow=1. Draining yields 0x100, 0x101, 0x102, 0x103 in order.
- Simultaneous push and pop at full:
  - Stimulus: full FIFO holding A..D; event_in=1 and out_ready=1 in the same cycle at count X.
  - Response: head A is popped, level stays 4, no drop occurs, and the drain order is B, C, D, X.
- Wrap-around:
  - Stimulus: count_in sequence 0xFFFF_FFFF_FFFF_FFFE, 0xFFFF_FFFF_FFFF_FFFF, 0, 1.
  - Response: mono_err stays 0. An event at count 0 captures the value 0.
- Monotonic violation:
  - Stimulus: count_in 5, 6, 6, 7.
  - Response: mono_err=1 after the edge sampling the second 6, and it stays 1 through 20 more correct cycles until rst.
- Reset mid-operation:
  - Stimulus: 3 entries stored with overflow=1; assert rst for 1 cycle while event_in=1.
  - Response: out_valid=0, out_level=0, drop_count=0, overflow=0. The event in the reset cycle is not captured. The first checked count is two cycles after rst falls.
